// File: rtl/servant_uart_rx.sv
// servant_uart_rx: 8N1 UART receiver with a small first-word-fall-through FIFO.
// A two-flop synchronizer feeds a mid-bit sampling FSM. Completed bytes are
// pushed into a 2**AW deep FIFO that is drained through a valid/ready handshake.
// Define SERVANT_UART_RX_PARITY_EN for 8E1 framing (adds a PARITY state and
// an even-parity check before the byte is accepted).
module servant_uart_rx #(
    parameter int unsigned DIV = 280,
    parameter int unsigned AW  = 2
) (
    input  logic       i_wb_clk,
    input  logic       i_wb_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int unsigned CW    = $clog2(DIV);
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
    localparam logic [AW:0]   CNT_CAP  = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
`ifdef SERVANT_UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // Synchronizer
    logic rx_meta_q;
    logic rx_sync_q;

    // Receive FSM
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0]    bit_idx_q;
    logic [2:0]    bit_idx_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
`ifdef SERVANT_UART_RX_PARITY_EN
    logic          parity_q;
    logic          parity_d;
`endif
    logic          push_req_c;
    logic          frame_err_q;
    logic          frame_err_d;

    // FIFO
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          pop_c;
    logic          push_ok_c;
    logic          overrun_q;
    logic          overrun_d;

    // Two-flop synchronizer; resets to the idle level so no start is seen out of reset
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receive FSM state register
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q   <= WAIT_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef SERVANT_UART_RX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
`ifdef SERVANT_UART_RX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Receive FSM next state: every action fires when the bit-time counter hits zero
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q - CW'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
`ifdef SERVANT_UART_RX_PARITY_EN
        parity_d    = parity_q;
`endif
        push_req_c  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            WAIT_IDLE: begin
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (!rx_sync_q) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == '0) begin
                    if (!rx_sync_q) begin
                        cnt_d     = CNT_FULL;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end else begin
                        // Line went back high before mid-start: treat as a glitch
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                if (cnt_q == '0) begin
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    cnt_d     = CNT_FULL;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef SERVANT_UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef SERVANT_UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    parity_d = rx_sync_q;
                    cnt_d    = CNT_FULL;
                    state_d  = STOP;
                end
            end
`endif

            STOP: begin
                if (cnt_q == '0) begin
                    if (!rx_sync_q) begin
                        // Low stop bit: possibly a break, wait for the line to recover
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
`ifdef SERVANT_UART_RX_PARITY_EN
                    end else if ((^shift_q) ^ parity_q) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
`endif
                    end else begin
                        push_req_c = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end

            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    // FIFO next state; a full FIFO still accepts a push when a pop frees a slot this cycle
    always_comb begin
        pop_c     = (count_q != '0) && i_ready;
        push_ok_c = push_req_c && ((count_q < CNT_CAP) || pop_c);
        overrun_d = push_req_c && !push_ok_c;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok_c, pop_c})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, occupancy and error pulses
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // FIFO storage; cleared on reset so the head is never X
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_c) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign o_data      = mem_q[rd_ptr_q];
    assign o_valid     = (count_q != '0);
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_servant_uart_rx.sv
// Directed bench for servant_uart_rx with a byte scoreboard and error-pulse counters.
module tb_servant_uart_rx;

    localparam int unsigned DIV = 16;
    localparam int unsigned AW  = 2;
`ifdef SERVANT_UART_RX_PARITY_EN
    localparam bit PARITY = 1'b1;
    localparam int NBITS  = 10;
`else
    localparam bit PARITY = 1'b0;
    localparam int NBITS  = 9;
`endif
    // Stop sample lands 2+DIV/2+NBITS*DIV after the falling edge; data visible one cycle later
    localparam int LAT = 2 + DIV / 2 + NBITS * DIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       fe;
    logic       ov;

    always #5 clk = ~clk;

    servant_uart_rx #(.DIV(DIV), .AW(AW)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst   (rst),
        .i_rx       (rx),
        .o_data     (data),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_frame_err(fe),
        .o_overrun  (ov)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         pop_cnt = 0;
    int         fall_cyc = 0;
    int         last_pop_cyc = 0;
    int         ready_cyc = 0;
    logic [7:0] exp_b;
    logic [7:0] sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: compare every handshaked byte against the scoreboard
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (valid && ready) begin
                check("pop_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    check("rx_byte", {24'h0, data}, {24'h0, exp_b});
                end
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            if (fe) fe_cnt++;
            if (ov) ov_cnt++;
            if (fe || ov) check("err_exclusive", 32'(fe && ov), 32'd0);
        end
    end

    task automatic drive_bit(input logic v);
        @(posedge clk);
        #1 rx = v;
        repeat (DIV - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_low, input logic par_flip);
        @(posedge clk);
        #1 rx = 1'b0;
        fall_cyc = cyc;
        repeat (DIV - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PARITY) drive_bit((^b) ^ par_flip);
        for (int i = 0; i < stop_low; i++) drive_bit(1'b0);
        drive_bit(1'b1);
    endtask

    task automatic idle_bits(input int n);
        repeat (n * DIV) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rb;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", {24'h0, data}, 32'h0);
        check("rst_fe", 32'(fe), 32'd0);
        check("rst_ov", 32'(ov), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_bits(1);

        // Two back-to-back frames, with latency of the first byte
        sb.push_back(8'h55);
        send_frame(8'h55, 0, 1'b0);
        check("t1_latency", 32'(last_pop_cyc - fall_cyc), 32'(LAT));
        sb.push_back(8'hA3);
        send_frame(8'hA3, 0, 1'b0);
        idle_bits(2);
        check("t1_pops", 32'(pop_cnt), 32'd2);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);
        check("t1_fe", 32'(fe_cnt), 32'd0);
        check("t1_ov", 32'(ov_cnt), 32'd0);

        // Short low glitch is rejected, next frame received
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        idle_bits(1);
        check("t2_glitch_pops", 32'(pop_cnt), 32'd2);
        check("t2_glitch_fe", 32'(fe_cnt), 32'd0);
        sb.push_back(8'h0F);
        send_frame(8'h0F, 0, 1'b0);
        idle_bits(2);
        check("t2_pops", 32'(pop_cnt), 32'd3);

        // Stop bit held low: one frame error, byte dropped, recovery
        send_frame(8'h81, 3, 1'b0);
        idle_bits(1);
        check("t3_fe", 32'(fe_cnt), 32'd1);
        check("t3_no_pop", 32'(pop_cnt), 32'd3);
        sb.push_back(8'h7E);
        send_frame(8'h7E, 0, 1'b0);
        idle_bits(2);
        check("t3_pops", 32'(pop_cnt), 32'd4);
        check("t3_fe_once", 32'(fe_cnt), 32'd1);

        // Overrun: five frames into a four-deep FIFO with the consumer stalled
        @(posedge clk);
        #1 ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            rb = 8'(i);
            if (i <= 4) sb.push_back(rb);
            send_frame(rb, 0, 1'b0);
        end
        idle_bits(1);
        check("t4_ov", 32'(ov_cnt), 32'd1);
        check("t4_valid", 32'(valid), 32'd1);
        check("t4_head", {24'h0, data}, 32'h01);
        check("t4_fe", 32'(fe_cnt), 32'd1);
        @(posedge clk);
        #1 ready = 1'b1;
        ready_cyc = cyc;
        repeat (4) @(posedge clk);
        #1;
        check("t4_drained", 32'(valid), 32'd0);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);
        check("t4_pops", 32'(pop_cnt), 32'd8);
        check("t4_consecutive", 32'(last_pop_cyc - ready_cyc), 32'd3);

        // Reset late in data bit 3 (line low); rest of frame yields nothing
        rb = 8'hF1;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (DIV - 1) @(posedge clk);
        for (int i = 0; i < 3; i++) drive_bit(rb[i]);
        @(posedge clk);
        #1 rx = rb[3];
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t5_rst_valid", 32'(valid), 32'd0);
        check("t5_rst_data", {24'h0, data}, 32'h0);
        check("t5_rst_fe", 32'(fe), 32'd0);
        check("t5_rst_ov", 32'(ov), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        for (int i = 4; i < 8; i++) drive_bit(rb[i]);
        if (PARITY) drive_bit(^rb);
        drive_bit(1'b1);
        idle_bits(2);
        check("t5_no_pop", 32'(pop_cnt), 32'd8);
        check("t5_no_fe", 32'(fe_cnt), 32'd1);
        sb.push_back(8'h3C);
        send_frame(8'h3C, 0, 1'b0);
        idle_bits(2);
        check("t5_pops", 32'(pop_cnt), 32'd9);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

`ifdef SERVANT_UART_RX_PARITY_EN
        // Even parity: correct parity bit accepted, wrong one flagged
        sb.push_back(8'h07);
        send_frame(8'h07, 0, 1'b0);
        idle_bits(1);
        check("t6_good_pop", 32'(pop_cnt), 32'd10);
        send_frame(8'h07, 0, 1'b1);
        idle_bits(2);
        check("t6_bad_fe", 32'(fe_cnt), 32'd2);
        check("t6_bad_no_pop", 32'(pop_cnt), 32'd10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/servant_uart_rx.md
Name: servant_uart_rx

Overview:
- Synthesizable 8N1 UART receiver for the servant SoC.
- Consumes the serial line produced by the SoC's bit-banged GPIO/UART output (the `q` pin).
- Turns that line into bytes, buffered in a small first-word-fall-through FIFO with a valid/ready handshake.
- Used on-chip for loopback/self-check and as the receive half of a future Wishbone UART peripheral.

Parameters:
- DIV, 280, clocks per bit; 16.13 MHz / 57600 baud. Must be ≥ 8.
- AW, 2, FIFO address width; depth = 2**AW entries.

Ports:
- i_wb_clk  in  1  system clock; all logic on the rising edge.
- i_wb_rst  in  1  synchronous reset, active-high.
- i_rx  in  1  asynchronous serial line; idle high.
- o_data  out  8  byte at the FIFO head; valid while o_valid=1.
- o_valid  out  1  FIFO not empty.
- i_ready  in  1  consumer accepts o_data when o_valid & i_ready.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low (or parity error, see below).
- o_overrun  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.

Behaviour:
- Reset (i_wb_rst=1 at a clock edge):
  - Synchronizer flops are set to 1.
  - FIFO is emptied; o_valid=0, o_data=0, o_frame_err=0, o_overrun=0.
  - The state machine goes to WAIT_IDLE and the bit counter is cleared.
  - Reset mid-frame therefore never mis-detects a data 0 as a start bit.
- Input synchronizer: two flops on i_rx produce `rxs`, which lags i_rx by 2 cycles. All decisions use rxs.
- Counter `cnt` is loaded on state entry and decrements every cycle; actions fire when cnt==0.
- States:
  - WAIT_IDLE: stay until rxs==1, then go to IDLE.
  - IDLE: when rxs==0, load cnt=DIV/2-1 (integer division) and go to START.
  - START: at cnt==0, if rxs==0 load cnt=DIV-1, bit index=0, go to DATA; if rxs==1 (glitch), go to IDLE with no flags.
  - DATA: at cnt==0, shift rxs into bit 7 of the shift register (LSB first) and reload cnt=DIV-1. After the 8th sample, go to STOP.
  - STOP: at cnt==0, sample rxs:
    - rxs==1: push the byte, go to IDLE.
    - rxs==0: o_frame_err=1 for one cycle, byte discarded, go to WAIT_IDLE (break/low-line handling).
- Sample points fall at mid-bit: 2 + DIV/2 + k·DIV cycles after the i_rx falling edge, for k = 0 (start), 1..8 (data), 9 (stop).
- FIFO:
  - Depth 2**AW with wrapping read/write pointers and an (AW+1)-bit occupancy count.
  - o_data/o_valid come directly from the head entry and count≠0.
  - Pop when o_valid & i_ready.
  - Push is accepted if count < 2**AW, or if a pop occurs in the same cycle.
  - Otherwise o_overrun=1 for one cycle and the new byte is dropped; FIFO contents are unchanged.
  - A pushed byte is visible on o_valid/o_data the cycle after the STOP sample.
  - Simultaneous push and pop leaves count unchanged.
  - Pop on empty is impossible by construction (o_valid=0).
- o_data is don't-care when o_valid=0 but must not be X after reset.
- o_frame_err and o_overrun are never asserted in the same cycle.

Optional Feature:
- Macro: SERVANT_UART_RX_PARITY_EN
- Defined (8E1 framing):
  - A PARITY state sits between DATA and STOP.
  - At cnt==0 it samples the parity bit and reloads cnt=DIV-1.
  - At STOP, the byte is pushed only if stop==1 and the XOR of 8 data bits and the parity bit ==0.
  - A parity mismatch with a good stop bit pulses o_frame_err and goes to IDLE (not WAIT_IDLE).
- Undefined: 8N1 exactly as above; no PARITY state or logic is present.

Test Plan:
- DIV=16, AW=2; send 0x55 then 0xA3 at 16 clocks/bit with i_ready=1 -> o_valid pulses twice with o_data=0x55 then 0xA3, each 1 cycle after the stop-bit sample; no error pulses.
- i_rx low for 5 cycles only (glitch) -> returns to IDLE; no o_valid, no flags; an immediately following 0x0F frame is received correctly.
- Frame 0x81 with stop bit held low for 3 bit-times, then high -> one o_frame_err pulse, no o_valid; the next frame 0x7E is received once the line is high.
- i_ready=0; send 0x01..0x05 -> FIFO holds 0x01..0x04 (o_data=0x01); one o_overrun pulse at the 5th stop sample. Then i_ready=1 -> pops 0x01,0x02,0x03,0x04 on consecutive cycles.
- Assert i_wb_rst during data bit 3 of a frame while the data line is low -> outputs cleared; the receiver waits for line high; the remainder of the frame produces no byte; the following 0x3C is received.
- With SERVANT_UART_RX_PARITY_EN: 0x07 sent with parity bit 1 -> received; 0x07 sent with parity bit 0 -> o_frame_err pulse, no o_valid.
